// File: rtl/ws_slave_ch_pkg.sv
// Shared types for the slave-channel recorder: FSM state encoding used by the
// recorder and visible on its debug port.
package ws_slave_ch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } ws_state_e;

endpackage

// File: rtl/ws_slave_ch_edge_det.sv
// Input synchronizer, antibounce delay line and registered edge/polarity strobe.
// Latency from ch to o_edge is Na+3 clocks, matching the trigger channel.
module ws_slave_ch_edge_det #(
  parameter int Na = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ch,
  output logic o_edge,
  output logic o_pol
);

  logic          r_ch_sync;
  logic [Na-1:0] r_dl;
  logic          r_s_ch;
  logic          r_ss_ch;
  logic          r_edge;
  logic          r_pol;
  logic          w_stable;

  assign w_stable = (r_dl == '0) || (r_dl == '1);

  // s_ch only follows the line once the whole delay line agrees, so any
  // s_ch/ss_ch difference is already a debounced edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_sync <= 1'b0;
      r_dl      <= '0;
      r_s_ch    <= 1'b0;
      r_ss_ch   <= 1'b0;
      r_edge    <= 1'b0;
      r_pol     <= 1'b0;
    end else begin
      r_ch_sync <= i_ch;
      r_dl      <= {r_dl[Na-2:0], r_ch_sync};
      if (w_stable) begin
        r_s_ch <= r_dl[Na-1];
      end
      r_ss_ch <= r_s_ch;
      r_edge  <= (r_s_ch != r_ss_ch);
      r_pol   <= r_s_ch;
    end
  end

  assign o_edge = r_edge;
  assign o_pol  = r_pol;

endmodule

// File: rtl/ws_slave_ch.sv
// Slave-channel recorder: stores timestamped edges of ch inside each trigger
// window and drains a header word plus one word per edge over valid/ready.
module ws_slave_ch
  import ws_slave_ch_pkg::*;
#(
  parameter int Nm = 16,
  parameter int Nc = 32,
  parameter int Na = 5,
  parameter int Nb = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ch,
  input  logic          st_start,
  input  logic          st_rdy,
  input  logic [Nm-1:0] m_cnt,
  input  logic [Nc-1:0] p_cnt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_hdr,
  output logic [Nc-1:0] out_data,
  output logic [Nb:0]   out_cnt,
  output logic          out_ovf,
  output logic          st_miss,
  output ws_state_e     dbg_state
);

  // Stream handshake: a word transfers on a clock edge where out_valid and
  // out_ready are both high; out_valid never drops and the word never changes
  // while waiting for out_ready.

  localparam int          DEPTH   = 1 << Nb;
  localparam logic [Nb:0] CNT_ONE = (Nb+1)'(1);

  ws_state_e     r_state;
  logic [Nm:0]   r_buf [DEPTH];
  logic [Nb:0]   r_cnt;
  logic [Nb:0]   r_rd;
  logic          r_ovf;
  logic [Nc-1:0] r_p_lat;
  logic          r_out_valid;
  logic          r_out_hdr;
  logic [Nc-1:0] r_out_data;
  logic [Nb:0]   r_out_cnt;
  logic          r_out_ovf;
  logic          r_st_miss;

  logic          w_edge;
  logic          w_pol;
  logic          w_armed_edge;
  logic          w_full;
  logic          w_store;
  logic [Nb:0]   w_cnt_nxt;
  logic          w_ovf_nxt;
  logic          w_hs;
  logic          w_last;

  ws_slave_ch_edge_det #(.Na(Na)) u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ch   (ch),
    .o_edge (w_edge),
    .o_pol  (w_pol)
  );

  // The count doubles as the write pointer; its MSB marks a full buffer.
  assign w_armed_edge = (r_state == ST_ARMED) && !st_start && w_edge;
  assign w_full       = r_cnt[Nb];
  assign w_store      = w_armed_edge && !w_full;
  assign w_cnt_nxt    = w_store ? (r_cnt + CNT_ONE) : r_cnt;
  assign w_ovf_nxt    = r_ovf | (w_armed_edge & w_full);
  assign w_hs         = r_out_valid & out_ready;
  assign w_last       = (r_rd == r_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_cnt       <= '0;
      r_rd        <= '0;
      r_ovf       <= 1'b0;
      r_p_lat     <= '0;
      r_out_valid <= 1'b0;
      r_out_hdr   <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
      r_st_miss   <= 1'b0;
    end else begin
      r_st_miss <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (st_start) begin
            r_state <= ST_ARMED;
            r_p_lat <= p_cnt;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (st_start) begin
            r_p_lat <= p_cnt;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end else begin
            if (w_store) begin
              r_buf[r_cnt[Nb-1:0]] <= {w_pol, m_cnt};
            end
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            // Header uses the next count so a same-cycle edge is reported.
            if (st_rdy) begin
              r_state     <= ST_DRAIN;
              r_rd        <= '0;
              r_out_valid <= 1'b1;
              r_out_hdr   <= 1'b1;
              r_out_data  <= r_p_lat;
              r_out_cnt   <= w_cnt_nxt;
              r_out_ovf   <= w_ovf_nxt;
            end
          end
        end
        ST_DRAIN: begin
          if (st_start) begin
            r_st_miss <= 1'b1;
          end
          if (w_hs) begin
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_out_hdr   <= 1'b0;
              r_out_data  <= '0;
              r_out_cnt   <= '0;
              r_out_ovf   <= 1'b0;
            end else begin
              r_out_hdr  <= 1'b0;
              r_out_cnt  <= '0;
              r_out_ovf  <= 1'b0;
              r_out_data <= Nc'(r_buf[r_rd[Nb-1:0]]);
              r_rd       <= r_rd + CNT_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_hdr   = r_out_hdr;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;
  assign st_miss   = r_st_miss;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ws_slave_ch.sv
// Directed bench for ws_slave_ch: window table plus hand-written corner sequences.
module tb_ws_slave_ch;
  import ws_slave_ch_pkg::*;

  localparam int Nm  = 16;
  localparam int Nc  = 32;
  localparam int Na  = 5;
  localparam int Nb  = 3;
  localparam int LAT = Na + 3;
  localparam int W   = 1 + Nc + (Nb + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ch = 1'b0;
  logic          st_start = 1'b0;
  logic          st_rdy = 1'b0;
  logic          out_ready = 1'b0;
  logic [Nm-1:0] m_cnt = '0;
  logic [Nc-1:0] p_cnt = '0;
  logic          out_valid;
  logic          out_hdr;
  logic [Nc-1:0] out_data;
  logic [Nb:0]   out_cnt;
  logic          out_ovf;
  logic          st_miss;
  ws_state_e     dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [Nc-1:0] p;
    logic [Nm-1:0] m0;
    int            n;
    int            s0;
    int            gap;
    logic [3:0]    rdy;
    logic [Nb:0]   exp_cnt;
    logic          exp_ovf;
  } win_t;

  win_t tbl[6];

  ws_slave_ch #(.Nm(Nm), .Nc(Nc), .Na(Na), .Nb(Nb)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch        (ch),
    .st_start  (st_start),
    .st_rdy    (st_rdy),
    .m_cnt     (m_cnt),
    .p_cnt     (p_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hdr   (out_hdr),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .st_miss   (st_miss),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] hdr_word(input logic [Nc-1:0] p, input logic [Nb:0] c,
                                           input logic o);
    return {1'b1, p, c, o};
  endfunction

  function automatic logic [W-1:0] edge_word(input logic pol, input logic [Nm-1:0] stamp);
    logic [Nc-1:0] d;
    d              = '0;
    d[Nm]          = pol;
    d[Nm-1:0]      = stamp;
    return {1'b0, d, {(Nb+1){1'b0}}, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic wait_m(input logic [Nm-1:0] v);
    int g = 0;
    while (m_cnt != v && g < 70000) begin
      step();
      g++;
    end
    if (m_cnt != v) begin
      total++;
      bad++;
      $display("FAIL wait_m: got %0h expected %0h", m_cnt, v);
    end
  endtask

  task automatic open_window(input logic [Nc-1:0] p, input logic [Nm-1:0] m0);
    st_start = 1'b1;
    p_cnt    = p;
    m_cnt    = m0;
    step();
    st_start = 1'b0;
  endtask

  // Toggle ch so that edge i is strobed while m_cnt == s0 + i*gap.
  task automatic make_edges(input int n, input int s0, input int gap, input int push_lim);
    logic pol;
    int   t;
    for (int i = 0; i < n; i++) begin
      t = s0 + i * gap;
      wait_m(Nm'(t - LAT));
      pol = ~ch;
      ch  = pol;
      if (i < push_lim) exp_q.push_back(edge_word(pol, Nm'(t)));
    end
  endtask

  task automatic pulse_rdy();
    st_rdy = 1'b1;
    step();
    st_rdy = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat);
    int           k    = 0;
    logic         held = 1'b0;
    logic [W-1:0] prev = '0;
    logic [W-1:0] cur;
    while (exp_q.size() > 0 && k < 300) begin
      out_ready = pat[k % 4];
      cur = {out_hdr, out_data, out_cnt, out_ovf};
      if (held) check("hold", cur, prev);
      if (out_valid && out_ready) begin
        check("word", cur, exp_q.pop_front());
        held = 1'b0;
      end else begin
        held = out_valid;
        prev = cur;
      end
      step();
      k++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b0;
    check("end_valid", W'(out_valid), W'(0));
    check("end_state", W'(dbg_state), W'(ST_IDLE));
  endtask

  task automatic run_window(input win_t w);
    exp_q.push_back(hdr_word(w.p, w.exp_cnt, w.exp_ovf));
    open_window(w.p, w.m0);
    make_edges(w.n, w.s0, w.gap, int'(w.exp_cnt));
    if (w.n > 0) wait_m(Nm'(w.s0 + (w.n - 1) * w.gap + 2));
    else repeat (20) step();
    check("armed_state", W'(dbg_state), W'(ST_ARMED));
    check("armed_valid", W'(out_valid), W'(0));
    pulse_rdy();
    drain(w.rdy);
  endtask

  initial begin
    tbl[0] = '{p: 32'd7,          m0: 16'h0000, n: 2,  s0: 10,        gap: 10, rdy: 4'b1111,
               exp_cnt: 4'd2, exp_ovf: 1'b0};
    tbl[1] = '{p: 32'h1234_5678, m0: 16'h0000, n: 10, s0: 12,        gap: 12, rdy: 4'b1111,
               exp_cnt: 4'd8, exp_ovf: 1'b1};
    tbl[2] = '{p: 32'hFFFF_FFFF, m0: 16'h0000, n: 8,  s0: 10,        gap: 9,  rdy: 4'b1001,
               exp_cnt: 4'd8, exp_ovf: 1'b0};
    tbl[3] = '{p: 32'd3,          m0: 16'h0000, n: 0,  s0: 0,         gap: 0,  rdy: 4'b1111,
               exp_cnt: 4'd0, exp_ovf: 1'b0};
    tbl[4] = '{p: 32'h0000_00A5, m0: 16'h0000, n: 9,  s0: 10,        gap: 10, rdy: 4'b1001,
               exp_cnt: 4'd8, exp_ovf: 1'b1};
    tbl[5] = '{p: 32'd100,        m0: 16'hFFE0, n: 1,  s0: 32'hFFF0, gap: 10, rdy: 4'b0110,
               exp_cnt: 4'd1, exp_ovf: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_word", W'({out_hdr, out_data, out_cnt, out_ovf}), W'(0));
    check("rst_miss", W'(st_miss), W'(0));
    check("rst_state", W'(dbg_state), W'(ST_IDLE));
    rst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 6; i++) begin
      run_window(tbl[i]);
      repeat (2) step();
    end

    // st_start during drain: miss pulse, drain unaffected, no new window
    exp_q.push_back(hdr_word(32'd55, 4'd1, 1'b0));
    open_window(32'd55, 16'h0000);
    make_edges(1, 10, 10, 1);
    wait_m(16'd12);
    pulse_rdy();
    st_start = 1'b1;
    p_cnt    = 32'd99;
    step();
    st_start = 1'b0;
    check("miss_pulse", W'(st_miss), W'(1));
    step();
    check("miss_clear", W'(st_miss), W'(0));
    check("miss_drain", W'(dbg_state), W'(ST_DRAIN));
    drain(4'b1111);
    repeat (3) step();
    check("miss_norec", W'(dbg_state), W'(ST_IDLE));

    // Two-cycle glitch is filtered out
    exp_q.push_back(hdr_word(32'd77, 4'd0, 1'b0));
    open_window(32'd77, 16'h0000);
    repeat (3) step();
    ch = ~ch;
    repeat (2) step();
    ch = ~ch;
    repeat (20) step();
    pulse_rdy();
    drain(4'b1111);

    // Reset in the middle of ARMED discards the partial record
    open_window(32'd88, 16'h0000);
    make_edges(3, 10, 10, 0);
    wait_m(16'd35);
    check("pre_rst_state", W'(dbg_state), W'(ST_ARMED));
    rst_n = 1'b0;
    ch    = 1'b0;
    #1;
    check("mid_rst_state", W'(dbg_state), W'(ST_IDLE));
    check("mid_rst_out", W'({out_valid, out_hdr, out_data, out_cnt, out_ovf, st_miss}), W'(0));
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    exp_q.push_back(hdr_word(32'h42, 4'd0, 1'b0));
    open_window(32'h42, 16'h0000);
    repeat (25) step();
    pulse_rdy();
    drain(4'b1111);

    // Restart while ARMED drops earlier edges and relatches p_cnt
    open_window(32'h10, 16'h0000);
    make_edges(2, 10, 10, 0);
    wait_m(16'd25);
    exp_q.push_back(hdr_word(32'h20, 4'd1, 1'b0));
    open_window(32'h20, 16'h0000);
    make_edges(1, 10, 10, 1);
    wait_m(16'd12);
    pulse_rdy();
    drain(4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
